// File: rtl/pipe_fwd.sv
// pipe_fwd: five-stage (IF/ID/EX/MEM/WB) in-order integer pipeline with an
// internal instruction memory and data memory, both filled through a load port
// while the core is frozen.
//
// Optional feature: define PIPE_FWD_FORWARD_EN to forward EX operands from
// EX/MEM and MEM/WB. When it is undefined, ID stalls on any register hazard
// against EX or MEM instead. Architectural results are the same either way.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst_n         asynchronous active-low reset
//   run           1 = fetch/execute, 0 = everything frozen, load port live
//   load_we       load strobe, honoured only while run = 0
//   load_sel      0 = instruction memory, 1 = data memory
//   load_addr     load word address (truncated to the target depth)
//   load_data     load word (instruction memory keeps bits [31:0])
//   halted        set once a HLT has retired, held until reset
//   retire_valid  one pulse per instruction leaving WB
//   retire_rd     destination of the retiring instruction (0 when none)
//   retire_data   value written by the retiring instruction (0 when none)
//   retire_count  retired instruction count, wraps
`default_nettype none

module pipe_fwd #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NREG       = 32,
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter int unsigned DMEM_DEPTH = 1024,
    localparam int unsigned LAW = $clog2(IMEM_DEPTH > DMEM_DEPTH ? IMEM_DEPTH : DMEM_DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            load_we,
    input  logic            load_sel,
    input  logic [LAW-1:0]  load_addr,
    input  logic [XLEN-1:0] load_data,
    output logic            halted,
    output logic            retire_valid,
    output logic [4:0]      retire_rd,
    output logic [XLEN-1:0] retire_data,
    output logic [XLEN-1:0] retire_count
);

    localparam int unsigned RW  = $clog2(NREG);
    localparam int unsigned IAW = $clog2(IMEM_DEPTH);
    localparam int unsigned DAW = $clog2(DMEM_DEPTH);

    localparam logic [5:0] OpAdd   = 6'b000000;
    localparam logic [5:0] OpSub   = 6'b000001;
    localparam logic [5:0] OpAnd   = 6'b000010;
    localparam logic [5:0] OpOr    = 6'b000011;
    localparam logic [5:0] OpSlt   = 6'b000100;
    localparam logic [5:0] OpMul   = 6'b000101;
    localparam logic [5:0] OpLw    = 6'b001000;
    localparam logic [5:0] OpSw    = 6'b001001;
    localparam logic [5:0] OpAddi  = 6'b001010;
    localparam logic [5:0] OpSubi  = 6'b001011;
    localparam logic [5:0] OpSlti  = 6'b001100;
    localparam logic [5:0] OpBneqz = 6'b001101;
    localparam logic [5:0] OpBeqz  = 6'b001110;

    typedef struct packed {
        logic            valid;
        logic [31:0]     instr;
        logic [IAW-1:0]  pc;
    } ifid_t;

    typedef struct packed {
        logic            valid;
        logic [5:0]      op;
`ifdef PIPE_FWD_FORWARD_EN
        logic [RW-1:0]   rs;
        logic [RW-1:0]   rt;
`endif
        logic [RW-1:0]   rd;
        logic            wen;
        logic            use_imm;
        logic            is_load;
        logic            is_store;
        logic            is_br;
        logic            br_eq;
        logic            is_halt;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
        logic [IAW-1:0]  pc;
    } idex_t;

    typedef struct packed {
        logic            valid;
        logic [RW-1:0]   rd;
        logic            wen;
        logic            is_load;
        logic            is_store;
        logic            is_halt;
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] sdata;
    } exmem_t;

    typedef struct packed {
        logic            valid;
        logic [RW-1:0]   rd;
        logic            wen;
        logic            is_halt;
        logic [XLEN-1:0] result;
    } memwb_t;

    logic [31:0]     imem [IMEM_DEPTH];
    logic [XLEN-1:0] dmem [DMEM_DEPTH];
    logic [XLEN-1:0] rf_q [NREG];

    logic [IAW-1:0]  pc_q, pc_d;
    logic            fetch_stop_q, fetch_stop_d;
    logic            halted_q, halted_d;
    logic [XLEN-1:0] count_q, count_d;
    ifid_t           ifid_q, ifid_d;
    idex_t           idex_q, idex_d, id_dec;
    exmem_t          exmem_q, exmem_d;
    memwb_t          memwb_q, memwb_d;

    logic [5:0]      id_op;
    logic [RW-1:0]   id_rs, id_rt, id_dst;
    logic            rs_used, rt_used, wr_raw, id_halt, stall, wb_we;
    logic [XLEN-1:0] ex_a, ex_b, ex_op2, ex_res, mem_rdata;
    logic [DAW-1:0]  mem_addr;
    logic [IAW-1:0]  br_target;
    logic            br_taken;

    assign wb_we = run & memwb_q.valid & memwb_q.wen;

    // ---------------- ID: decode and register read ----------------
    always_comb begin
        id_op   = ifid_q.instr[31:26];
        id_rs   = ifid_q.instr[21 +: RW];
        id_rt   = ifid_q.instr[16 +: RW];
        rs_used = 1'b0;
        rt_used = 1'b0;
        wr_raw  = 1'b0;
        id_dst  = '0;
        id_dec  = '0;
        id_dec.valid = ifid_q.valid;
        id_dec.op    = id_op;
        id_dec.pc    = ifid_q.pc;
        id_dec.imm   = XLEN'($signed(ifid_q.instr[15:0]));
        case (id_op)
            OpAdd, OpSub, OpAnd, OpOr, OpSlt, OpMul: begin
                rs_used = 1'b1;
                rt_used = 1'b1;
                wr_raw  = 1'b1;
                id_dst  = ifid_q.instr[11 +: RW];
            end
            OpAddi, OpSubi, OpSlti, OpLw: begin
                rs_used = 1'b1;
                wr_raw  = 1'b1;
                id_dst  = id_rt;
                id_dec.use_imm = 1'b1;
                id_dec.is_load = (id_op == OpLw);
            end
            OpSw: begin
                rs_used = 1'b1;
                rt_used = 1'b1;
                id_dec.use_imm  = 1'b1;
                id_dec.is_store = 1'b1;
            end
            OpBneqz, OpBeqz: begin
                rs_used = 1'b1;
                id_dec.is_br = 1'b1;
                id_dec.br_eq = (id_op == OpBeqz);
            end
            default: id_dec.is_halt = 1'b1;
        endcase
        id_dec.rd  = id_dst;
        // Writes to r0 are dropped at decode so they never forward or retire a value.
        id_dec.wen = wr_raw & (id_dst != '0);
`ifdef PIPE_FWD_FORWARD_EN
        id_dec.rs = id_rs;
        id_dec.rt = id_rt;
`endif
        // Read with write-through from the instruction currently in WB.
        id_dec.a = rf_q[id_rs];
        if (wb_we && memwb_q.rd == id_rs) id_dec.a = memwb_q.result;
        if (id_rs == '0) id_dec.a = '0;
        id_dec.b = rf_q[id_rt];
        if (wb_we && memwb_q.rd == id_rt) id_dec.b = memwb_q.result;
        if (id_rt == '0) id_dec.b = '0;
        id_halt = ifid_q.valid & id_dec.is_halt;
    end

    // ---------------- Hazard detection ----------------
    always_comb begin
`ifdef PIPE_FWD_FORWARD_EN
        // Only a load result is too late to forward into the next instruction.
        stall = ifid_q.valid & idex_q.valid & idex_q.is_load & idex_q.wen &
                ((rs_used & (idex_q.rd == id_rs)) | (rt_used & (idex_q.rd == id_rt)));
`else
        stall = ifid_q.valid & (
                (idex_q.valid & idex_q.wen &
                 ((rs_used & (idex_q.rd == id_rs)) | (rt_used & (idex_q.rd == id_rt)))) |
                (exmem_q.valid & exmem_q.wen &
                 ((rs_used & (exmem_q.rd == id_rs)) | (rt_used & (exmem_q.rd == id_rt)))));
`endif
    end

    // ---------------- EX: operands, ALU, branch ----------------
    always_comb begin
        ex_a = idex_q.a;
        ex_b = idex_q.b;
`ifdef PIPE_FWD_FORWARD_EN
        // MEM/WB first, then EX/MEM overrides so the youngest producer wins.
        if (memwb_q.valid && memwb_q.wen && memwb_q.rd == idex_q.rs) ex_a = memwb_q.result;
        if (memwb_q.valid && memwb_q.wen && memwb_q.rd == idex_q.rt) ex_b = memwb_q.result;
        if (exmem_q.valid && exmem_q.wen && exmem_q.rd == idex_q.rs) ex_a = exmem_q.result;
        if (exmem_q.valid && exmem_q.wen && exmem_q.rd == idex_q.rt) ex_b = exmem_q.result;
`endif
        ex_op2 = idex_q.use_imm ? idex_q.imm : ex_b;
        case (idex_q.op)
            OpSub, OpSubi: ex_res = ex_a - ex_op2;
            OpAnd:         ex_res = ex_a & ex_op2;
            OpOr:          ex_res = ex_a | ex_op2;
            OpSlt, OpSlti: ex_res = XLEN'(ex_a < ex_op2);
            OpMul:         ex_res = ex_a * ex_op2;
            default:       ex_res = ex_a + ex_op2;
        endcase
        br_target = idex_q.pc + IAW'(1) + idex_q.imm[IAW-1:0];
        br_taken  = idex_q.valid & idex_q.is_br &
                    (idex_q.br_eq ? (ex_a == '0) : (ex_a != '0));
    end

    // ---------------- MEM ----------------
    assign mem_addr  = exmem_q.result[DAW-1:0];
    assign mem_rdata = dmem[mem_addr];

    // ---------------- Next state ----------------
    always_comb begin
        pc_d         = pc_q;
        fetch_stop_d = fetch_stop_q;
        halted_d     = halted_q;
        count_d      = count_q;
        ifid_d       = ifid_q;
        idex_d       = idex_q;
        exmem_d      = exmem_q;
        memwb_d      = memwb_q;
        if (run) begin
            memwb_d.valid   = exmem_q.valid;
            memwb_d.rd      = exmem_q.rd;
            memwb_d.wen     = exmem_q.wen;
            memwb_d.is_halt = exmem_q.is_halt;
            memwb_d.result  = exmem_q.is_load ? mem_rdata : exmem_q.result;

            exmem_d.valid    = idex_q.valid;
            exmem_d.rd       = idex_q.rd;
            exmem_d.wen      = idex_q.wen;
            exmem_d.is_load  = idex_q.is_load;
            exmem_d.is_store = idex_q.is_store;
            exmem_d.is_halt  = idex_q.is_halt;
            exmem_d.result   = ex_res;
            exmem_d.sdata    = ex_b;

            if (br_taken) begin
                ifid_d = '0;
                idex_d = '0;
                pc_d   = br_target;
            end else if (stall) begin
                idex_d = '0;
            end else begin
                idex_d = id_dec;
                // A HLT in ID squashes the fetch behind it and stops fetching for good.
                if (fetch_stop_q || id_halt) begin
                    ifid_d = '0;
                end else begin
                    ifid_d.valid = 1'b1;
                    ifid_d.instr = imem[pc_q];
                    ifid_d.pc    = pc_q;
                    pc_d         = pc_q + IAW'(1);
                end
                fetch_stop_d = fetch_stop_q | id_halt;
            end

            halted_d = halted_q | (memwb_q.valid & memwb_q.is_halt);
            if (memwb_q.valid) count_d = count_q + XLEN'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= '0;
            fetch_stop_q <= 1'b0;
            halted_q     <= 1'b0;
            count_q      <= '0;
            ifid_q       <= '0;
            idex_q       <= '0;
            exmem_q      <= '0;
            memwb_q      <= '0;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            pc_q         <= pc_d;
            fetch_stop_q <= fetch_stop_d;
            halted_q     <= halted_d;
            count_q      <= count_d;
            ifid_q       <= ifid_d;
            idex_q       <= idex_d;
            exmem_q      <= exmem_d;
            memwb_q      <= memwb_d;
            if (wb_we) rf_q[memwb_q.rd] <= memwb_q.result;
        end
    end

    // Memories are not reset; stores are gated by rst_n so a reset edge never
    // lets an in-flight SW land.
    always_ff @(posedge clk) begin
        if (!run && load_we) begin
            if (load_sel) dmem[load_addr[DAW-1:0]] <= load_data;
        end else if (rst_n && run && exmem_q.valid && exmem_q.is_store) begin
            dmem[mem_addr] <= exmem_q.sdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!run && load_we && !load_sel) imem[load_addr[IAW-1:0]] <= 32'(load_data);
    end

    // ---------------- Outputs ----------------
    assign halted       = halted_q;
    assign retire_count = count_q;
    assign retire_valid = run & memwb_q.valid;
    assign retire_rd    = (retire_valid && memwb_q.wen) ? 5'(memwb_q.rd) : 5'd0;
    assign retire_data  = (retire_valid && memwb_q.wen) ? memwb_q.result : '0;

endmodule

`default_nettype wire

// File: tb/tb_pipe_fwd.sv
// Self-checking bench for pipe_fwd: a table of ALU instructions with expected
// retire records, plus directed sequences for forwarding/stall timing, load-use,
// branch flush, halt squash, mid-run reset and run freeze with loads.
`timescale 1ns/1ps

module tb_pipe_fwd;
    localparam int unsigned XLEN = 32;
    localparam int unsigned LAW  = 10;
    localparam int NT = 17;
`ifdef PIPE_FWD_FORWARD_EN
    localparam int GapDep  = 1;
    localparam int GapLoad = 2;
`else
    localparam int GapDep  = 3;
    localparam int GapLoad = 3;
`endif

    localparam logic [5:0] OpAdd = 6'b000000, OpSub = 6'b000001, OpAnd = 6'b000010;
    localparam logic [5:0] OpOr = 6'b000011, OpSlt = 6'b000100, OpMul = 6'b000101;
    localparam logic [5:0] OpLw = 6'b001000, OpSw = 6'b001001, OpAddi = 6'b001010;
    localparam logic [5:0] OpSubi = 6'b001011, OpSlti = 6'b001100, OpBneqz = 6'b001101;
    localparam logic [5:0] OpBeqz = 6'b001110;
    localparam logic [31:0] Hlt = 32'hFC00_0000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            run = 1'b0;
    logic            load_we = 1'b0;
    logic            load_sel = 1'b0;
    logic [LAW-1:0]  load_addr = '0;
    logic [XLEN-1:0] load_data = '0;
    logic            halted;
    logic            retire_valid;
    logic [4:0]      retire_rd;
    logic [XLEN-1:0] retire_data;
    logic [XLEN-1:0] retire_count;

    pipe_fwd dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .load_we      (load_we),
        .load_sel     (load_sel),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .halted       (halted),
        .retire_valid (retire_valid),
        .retire_rd    (retire_rd),
        .retire_data  (retire_data),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] data;
    } vec_t;

    vec_t        tbl [NT];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          idle_bad = 0;
    logic [4:0]  q_rd [$];
    logic [31:0] q_data [$];
    int          q_cyc [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Retire log, sampled on the falling edge away from state updates.
    always @(negedge clk) begin
        if (retire_valid) begin
            q_rd.push_back(retire_rd);
            q_data.push_back(retire_data);
            q_cyc.push_back(cyc);
        end else if (retire_rd != 5'd0 || retire_data != '0) begin
            idle_bad++;
        end
    end

    function automatic logic [31:0] rr(logic [5:0] op, int rd, int rs, int rt);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] ri(logic [5:0] op, int rt, int rs, int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input logic sel, input int addr, input logic [31:0] data);
        load_sel  = sel;
        load_addr = LAW'(addr);
        load_data = data;
        load_we   = 1'b1;
        step(1);
        load_we   = 1'b0;
    endtask

    task automatic clear_log();
        q_rd.delete();
        q_data.delete();
        q_cyc.delete();
    endtask

    task automatic do_reset();
        run   = 1'b0;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        clear_log();
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_valid"}, retire_valid, 0);
        chk({name, "_rd"}, retire_rd, 0);
        chk({name, "_data"}, retire_data, 0);
        chk({name, "_count"}, retire_count, 0);
        chk({name, "_halted"}, halted, 0);
    endtask

    // Runs until halted (bounded), then a few more cycles to prove nothing else retires.
    task automatic run_to_halt(input string name, input int maxc);
        int n;
        n = 0;
        start_cyc = cyc;
        run = 1'b1;
        while (!halted && n < maxc) begin
            step(1);
            n++;
        end
        chk({name, "_halt_reached"}, halted, 1);
        step(6);
        run = 1'b0;
        step(1);
    endtask

    task automatic chk_rec(input string name, input int i, input logic [4:0] rd,
                           input logic [31:0] data);
        if (i < q_rd.size()) chk($sformatf("%s_ret%0d", name, i), {q_rd[i], q_data[i]}, {rd, data});
        else chk($sformatf("%s_ret%0d_missing", name, i), q_rd.size(), i + 1);
    endtask

    task automatic load_table();
        for (int i = 0; i < NT; i++) load(1'b0, i, tbl[i].instr);
    endtask

    task automatic chk_table(input string name);
        chk({name, "_nret"}, q_rd.size(), NT);
        for (int i = 0; i < NT; i++) chk_rec(name, i, tbl[i].rd, tbl[i].data);
        chk({name, "_count"}, retire_count, NT);
    endtask

    initial begin
        // r1 = 10, r2 = -3; expected values worked by hand.
        tbl[0]  = '{ri(OpAddi, 1, 0, 10),   5'd1,  32'd10};
        tbl[1]  = '{ri(OpAddi, 2, 0, -3),   5'd2,  32'hFFFF_FFFD};
        tbl[2]  = '{rr(OpAdd, 3, 1, 2),     5'd3,  32'd7};
        tbl[3]  = '{rr(OpSub, 4, 1, 2),     5'd4,  32'd13};
        tbl[4]  = '{rr(OpAnd, 5, 1, 2),     5'd5,  32'd8};
        tbl[5]  = '{rr(OpOr, 6, 1, 2),      5'd6,  32'hFFFF_FFFF};
        tbl[6]  = '{rr(OpSlt, 7, 1, 2),     5'd7,  32'd1};
        tbl[7]  = '{rr(OpSlt, 8, 2, 1),     5'd8,  32'd0};
        tbl[8]  = '{rr(OpMul, 9, 1, 2),     5'd9,  32'hFFFF_FFE2};
        tbl[9]  = '{ri(OpSubi, 10, 1, 12),  5'd10, 32'hFFFF_FFFE};
        tbl[10] = '{ri(OpSlti, 11, 1, 11),  5'd11, 32'd1};
        tbl[11] = '{ri(OpSlti, 12, 1, 10),  5'd12, 32'd0};
        tbl[12] = '{rr(OpAdd, 0, 1, 1),     5'd0,  32'd0};
        tbl[13] = '{rr(OpAdd, 13, 0, 1),    5'd13, 32'd10};
        tbl[14] = '{ri(OpAddi, 14, 2, 3),   5'd14, 32'd0};
        tbl[15] = '{ri(OpBneqz, 0, 0, 5),   5'd0,  32'd0};
        tbl[16] = '{Hlt,                    5'd0,  32'd0};

        step(1);
        chk_idle("reset_state");

        // ---- A: ALU table, first-retire latency ----
        load_table();
        do_reset();
        chk_idle("post_reset");
        run_to_halt("alu", 200);
        chk_table("alu");
        if (q_cyc.size() > 0) chk("alu_first_latency", q_cyc[0] - start_cyc, 4);

        // ---- B: dependent ADD ----
        load(1'b0, 0, ri(OpAddi, 1, 0, 10));
        load(1'b0, 1, ri(OpAddi, 2, 0, 20));
        load(1'b0, 2, rr(OpAdd, 3, 1, 2));
        load(1'b0, 3, Hlt);
        do_reset();
        run_to_halt("dep", 100);
        chk("dep_nret", q_rd.size(), 4);
        chk_rec("dep", 0, 5'd1, 32'd10);
        chk_rec("dep", 1, 5'd2, 32'd20);
        chk_rec("dep", 2, 5'd3, 32'd30);
        chk_rec("dep", 3, 5'd0, 32'd0);
        chk("dep_count", retire_count, 4);
        if (q_cyc.size() >= 3) begin
            chk("dep_gap_indep", q_cyc[1] - q_cyc[0], 1);
            chk("dep_gap_add", q_cyc[2] - q_cyc[1], GapDep);
        end

        // ---- C: load-use ----
        load(1'b1, 5, 32'h55);
        load(1'b0, 0, ri(OpLw, 4, 0, 5));
        load(1'b0, 1, rr(OpAdd, 5, 4, 4));
        load(1'b0, 2, Hlt);
        do_reset();
        run_to_halt("lduse", 100);
        chk("lduse_nret", q_rd.size(), 3);
        chk_rec("lduse", 0, 5'd4, 32'h55);
        chk_rec("lduse", 1, 5'd5, 32'hAA);
        if (q_cyc.size() >= 2) chk("lduse_gap", q_cyc[1] - q_cyc[0], GapLoad);

        // ---- D: taken BEQZ flushes two slots ----
        load(1'b1, 0, 32'h1234);
        load(1'b0, 0, ri(OpBeqz, 0, 1, 2));
        load(1'b0, 1, ri(OpAddi, 6, 0, 1));
        load(1'b0, 2, ri(OpSw, 6, 0, 0));
        load(1'b0, 3, ri(OpAddi, 7, 0, 9));
        load(1'b0, 4, Hlt);
        do_reset();
        run_to_halt("br", 100);
        chk("br_nret", q_rd.size(), 3);
        chk_rec("br", 0, 5'd0, 32'd0);
        chk_rec("br", 1, 5'd7, 32'd9);
        chk_rec("br", 2, 5'd0, 32'd0);
        if (q_cyc.size() >= 2) chk("br_gap", q_cyc[1] - q_cyc[0], 3);
        chk("br_dmem0", dut.dmem[0], 32'h1234);

        // ---- E: instructions after HLT are squashed ----
        load(1'b0, 0, ri(OpAddi, 1, 0, 77));
        load(1'b0, 1, Hlt);
        load(1'b0, 2, ri(OpSw, 1, 0, 0));
        load(1'b0, 3, ri(OpAddi, 8, 0, 3));
        do_reset();
        run_to_halt("hlt", 100);
        chk("hlt_nret", q_rd.size(), 2);
        chk_rec("hlt", 0, 5'd1, 32'd77);
        chk_rec("hlt", 1, 5'd0, 32'd0);
        chk("hlt_count", retire_count, 2);
        chk("hlt_dmem0", dut.dmem[0], 32'h1234);
        run = 1'b1;
        step(10);
        run = 1'b0;
        step(1);
        chk("hlt_count_stuck", retire_count, 2);
        chk("hlt_still_halted", halted, 1);

        // ---- F: reset pulse mid-program ----
        load_table();
        do_reset();
        run = 1'b1;
        step(8);
        chk("rst_pre_count_nonzero", retire_count != 0, 1);
        rst_n = 1'b0;
        #1;
        chk_idle("rst_async");
        step(1);
        rst_n = 1'b1;
        clear_log();
        run_to_halt("rst", 200);
        chk_table("rst");

        // ---- G: run frozen for 5 cycles with a data load; load ignored while running ----
        load(1'b1, 9, 32'd0);
        load(1'b1, 10, 32'd0);
        load_table();
        do_reset();
        run = 1'b1;
        step(3);
        load_sel  = 1'b1;
        load_addr = LAW'(10);
        load_data = 32'hDEAD;
        load_we   = 1'b1;
        step(3);
        load_we = 1'b0;
        run     = 1'b0;
        load(1'b1, 9, 32'd7);
        step(4);
        run_to_halt("frz", 200);
        chk_table("frz");
        chk("frz_dmem9", dut.dmem[9], 32'd7);
        chk("frz_dmem10_ignored", dut.dmem[10], 32'd0);

        chk("idle_outputs_zero", idle_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
